// File: rtl/i2c_slave_if.sv
// Fabric-side byte handshake of the I2C target: write bytes out, read bytes in.
interface i2c_slave_if;
  logic [7:0] tx_data;
  logic       tx_data_needed;
  logic [7:0] rx_data;
  logic       rx_data_valid;
  logic       rx_nack;

  modport slave (
    input  tx_data,
    input  rx_nack,
    output tx_data_needed,
    output rx_data,
    output rx_data_valid
  );

  modport master (
    output tx_data,
    output rx_nack,
    input  tx_data_needed,
    input  rx_data,
    input  rx_data_valid
  );
endinterface

// File: rtl/i2c_slave.sv
// 7-bit-address I2C target: oversampled SCL/SDA, START/STOP detection,
// address match, byte delivery/fetch via pulse handshake, open-drain SDA.
module i2c_slave #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [6:0]  i_own_addr,
  i2c_slave_if.slave  fab,
  output logic        o_busy,
  output logic        o_addressed,
  output logic        o_read_mode,
  output logic        o_stop_det,
  inout  wire         io_sda,
  input  logic        i_scl
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] FILT_MAX = CNT_W'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_RX_BYTE,
    ST_RX_ACK,
    ST_TX_BYTE,
    ST_TX_ACK,
    ST_IGNORE
  } state_t;

  logic             scl_meta, scl_sync, scl_filt, scl_prev;
  logic             sda_meta, sda_sync, sda_filt, sda_prev;
  logic [CNT_W-1:0] scl_cnt, sda_cnt;

  state_t      state, state_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [6:0]  shift, shift_nxt;
  logic [6:0]  tx_sr, tx_sr_nxt;
  logic        phase, phase_nxt;
  logic        sda_low, sda_low_nxt;
  logic        ack_n, ack_n_nxt;
  logic [7:0]  rx_data, rx_data_nxt;
  logic        rx_valid, rx_valid_nxt;
  logic        tx_needed, tx_needed_nxt;
  logic        stop_pulse, stop_pulse_nxt;
  logic        busy, busy_nxt;
  logic        addressed, addressed_nxt;
  logic        read_mode, read_mode_nxt;

  logic scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;

  // Open-drain SDA: only ever pulls low.
  assign io_sda = sda_low ? 1'b0 : 1'bz;

  assign fab.rx_data        = rx_data;
  assign fab.rx_data_valid  = rx_valid;
  assign fab.tx_data_needed = tx_needed;
  assign o_busy      = busy;
  assign o_addressed = addressed;
  assign o_read_mode = read_mode;
  assign o_stop_det  = stop_pulse;

  // Two-flop synchronizers followed by a hold-for-FILTER_LEN glitch filter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_filt <= 1'b1;
      scl_prev <= 1'b1;
      scl_cnt  <= '0;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_filt <= 1'b1;
      sda_prev <= 1'b1;
      sda_cnt  <= '0;
    end else begin
      scl_meta <= i_scl;
      scl_sync <= scl_meta;
      sda_meta <= io_sda;
      sda_sync <= sda_meta;
      scl_prev <= scl_filt;
      sda_prev <= sda_filt;
      if (scl_sync == scl_filt) begin
        scl_cnt <= '0;
      end else if (scl_cnt == FILT_MAX) begin
        scl_filt <= scl_sync;
        scl_cnt  <= '0;
      end else begin
        scl_cnt <= scl_cnt + CNT_W'(1);
      end
      if (sda_sync == sda_filt) begin
        sda_cnt <= '0;
      end else if (sda_cnt == FILT_MAX) begin
        sda_filt <= sda_sync;
        sda_cnt  <= '0;
      end else begin
        sda_cnt <= sda_cnt + CNT_W'(1);
      end
    end
  end

  // One-clock edge strobes on the filtered lines; bus conditions need SCL high.
  assign scl_rise  = scl_filt & ~scl_prev;
  assign scl_fall  = ~scl_filt & scl_prev;
  assign sda_rise  = sda_filt & ~sda_prev;
  assign sda_fall  = ~sda_filt & sda_prev;
  assign start_det = sda_fall & scl_filt;
  assign stop_det  = sda_rise & scl_filt;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state and next-output logic; START/STOP override any bit activity.
  always_comb begin
    state_nxt      = state;
    bit_cnt_nxt    = bit_cnt;
    shift_nxt      = shift;
    tx_sr_nxt      = tx_sr;
    phase_nxt      = phase;
    sda_low_nxt    = sda_low;
    ack_n_nxt      = ack_n;
    rx_data_nxt    = rx_data;
    rx_valid_nxt   = 1'b0;
    tx_needed_nxt  = 1'b0;
    stop_pulse_nxt = 1'b0;
    busy_nxt       = busy;
    addressed_nxt  = addressed;
    read_mode_nxt  = read_mode;

    if (start_det) begin
      state_nxt     = ST_ADDR;
      bit_cnt_nxt   = 3'd0;
      phase_nxt     = 1'b0;
      sda_low_nxt   = 1'b0;
      addressed_nxt = 1'b0;
      busy_nxt      = 1'b1;
    end else if (stop_det) begin
      state_nxt      = ST_IDLE;
      sda_low_nxt    = 1'b0;
      busy_nxt       = 1'b0;
      addressed_nxt  = 1'b0;
      stop_pulse_nxt = 1'b1;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_ADDR: begin
          if (scl_rise) begin
            shift_nxt   = {shift[5:0], sda_filt};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (shift == i_own_addr) begin
                read_mode_nxt = sda_filt;
                addressed_nxt = 1'b1;
                phase_nxt     = 1'b0;
                state_nxt     = ST_ADDR_ACK;
              end else begin
                state_nxt = ST_IGNORE;
              end
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_rise && phase && read_mode) tx_needed_nxt = 1'b1;
          if (scl_fall) begin
            if (!phase) begin
              sda_low_nxt = 1'b1;
              phase_nxt   = 1'b1;
            end else begin
              phase_nxt   = 1'b0;
              bit_cnt_nxt = 3'd0;
              if (read_mode) begin
                tx_sr_nxt   = fab.tx_data[6:0];
                sda_low_nxt = ~fab.tx_data[7];
                state_nxt   = ST_TX_BYTE;
              end else begin
                sda_low_nxt = 1'b0;
                state_nxt   = ST_RX_BYTE;
              end
            end
          end
        end
        ST_RX_BYTE: begin
          if (scl_rise) begin
            shift_nxt   = {shift[5:0], sda_filt};
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_nxt  = {shift, sda_filt};
              rx_valid_nxt = 1'b1;
              ack_n_nxt    = fab.rx_nack;
              phase_nxt    = 1'b0;
              state_nxt    = ST_RX_ACK;
            end
          end
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            if (!phase) begin
              sda_low_nxt = ~ack_n;
              phase_nxt   = 1'b1;
            end else begin
              sda_low_nxt = 1'b0;
              phase_nxt   = 1'b0;
              bit_cnt_nxt = 3'd0;
              state_nxt   = ST_RX_BYTE;
            end
          end
        end
        ST_TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_low_nxt = 1'b0;
              bit_cnt_nxt = 3'd0;
              phase_nxt   = 1'b0;
              state_nxt   = ST_TX_ACK;
            end else begin
              sda_low_nxt = ~tx_sr[6];
              tx_sr_nxt   = {tx_sr[5:0], 1'b0};
              bit_cnt_nxt = bit_cnt + 3'd1;
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise && !phase) begin
            if (!sda_filt) begin
              tx_needed_nxt = 1'b1;
              phase_nxt     = 1'b1;
            end else begin
              sda_low_nxt = 1'b0;
              state_nxt   = ST_IGNORE;
            end
          end else if (scl_fall && phase) begin
            tx_sr_nxt   = fab.tx_data[6:0];
            sda_low_nxt = ~fab.tx_data[7];
            bit_cnt_nxt = 3'd0;
            phase_nxt   = 1'b0;
            state_nxt   = ST_TX_BYTE;
          end
        end
        ST_IGNORE: sda_low_nxt = 1'b0;
        default: begin
          sda_low_nxt = 1'b0;
          state_nxt   = ST_IDLE;
        end
      endcase
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bit_cnt    <= 3'd0;
      shift      <= 7'd0;
      tx_sr      <= 7'd0;
      phase      <= 1'b0;
      sda_low    <= 1'b0;
      ack_n      <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      tx_needed  <= 1'b0;
      stop_pulse <= 1'b0;
      busy       <= 1'b0;
      addressed  <= 1'b0;
      read_mode  <= 1'b0;
    end else begin
      bit_cnt    <= bit_cnt_nxt;
      shift      <= shift_nxt;
      tx_sr      <= tx_sr_nxt;
      phase      <= phase_nxt;
      sda_low    <= sda_low_nxt;
      ack_n      <= ack_n_nxt;
      rx_data    <= rx_data_nxt;
      rx_valid   <= rx_valid_nxt;
      tx_needed  <= tx_needed_nxt;
      stop_pulse <= stop_pulse_nxt;
      busy       <= busy_nxt;
      addressed  <= addressed_nxt;
      read_mode  <= read_mode_nxt;
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Randomized scoreboard bench for i2c_slave driven by a bit-banged I2C master.
module tb_i2c_slave;
  localparam int unsigned Q = 10;  // quarter SCL period in system clocks

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] own_addr;
  logic       m_scl, m_sda_low;
  logic       busy, addressed, read_mode, stop_det;
  wire        sda;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_if fab ();

  i2c_slave #(.FILTER_LEN(3)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_own_addr  (own_addr),
    .fab         (fab),
    .o_busy      (busy),
    .o_addressed (addressed),
    .o_read_mode (read_mode),
    .o_stop_det  (stop_det),
    .io_sda      (sda),
    .i_scl       (m_scl)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int rx_cnt = 0, txn_cnt = 0, stop_cnt = 0, dut_low = 0;

  logic [7:0] exp_rx[$];    // scoreboard of write bytes the fabric must see
  logic [7:0] tx_src[$];    // bytes the fabric model hands out on request
  logic [7:0] wr_bytes[$];
  bit         wr_nack[$];
  logic [7:0] rd_bytes[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a write byte is delivered.
  always @(negedge clk) begin
    if (fab.rx_data_valid === 1'b1) begin
      rx_cnt++;
      if (exp_rx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected act=0x%0h exp=none t=%0t", fab.rx_data, $time);
      end else begin
        chk("rx_data", 32'(fab.rx_data), 32'(exp_rx.pop_front()));
      end
    end
  end

  // Fabric model answering read-byte requests, plus event counters.
  always @(negedge clk) begin
    if (fab.tx_data_needed === 1'b1) begin
      txn_cnt++;
      if (tx_src.size() == 0) begin
        total++;
        bad++;
        fab.tx_data = 8'hFF;
        $display("FAIL tx_underrun act=request exp=none t=%0t", $time);
      end else begin
        fab.tx_data = tx_src.pop_front();
      end
    end
    if (stop_det === 1'b1) stop_cnt++;
    if (!m_sda_low && sda === 1'b0) dut_low++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(Q);
    m_sda_low = 1'b1; wait_clk(Q);
    m_scl = 1'b0;     wait_clk(Q);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(Q);
    m_sda_low = 1'b0; wait_clk(2 * Q);
  endtask

  task automatic write_bit(input bit b, input bit glitch);
    m_sda_low = !b;
    if (glitch) begin
      wait_clk(Q / 2);
      m_scl = 1'b1; wait_clk(1);
      m_scl = 1'b0; wait_clk(Q / 2);
    end else begin
      wait_clk(Q);
    end
    m_scl = 1'b1; wait_clk(2 * Q);
    m_scl = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output bit b);
    m_sda_low = 1'b0; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(Q);
    b = sda;          wait_clk(Q);
    m_scl = 1'b0;     wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output bit ack);
    bit a;
    for (int i = 7; i >= 0; i--) write_bit(d[i], i == glitch_bit);
    read_bit(a);
    ack = !a;
  endtask

  task automatic read_byte(output logic [7:0] d, input bit ack);
    logic [7:0] t;
    bit b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      t[i] = b;
    end
    d = t;
    write_bit(!ack, 1'b0);
  endtask

  task automatic stop_checks();
    int s0;
    s0 = stop_cnt;
    bus_stop();
    chk("stop_pulses", 32'(stop_cnt - s0), 32'd1);
    chk("busy_after_stop", 32'(busy), 32'd0);
    chk("addressed_after_stop", 32'(addressed), 32'd0);
  endtask

  // Write transfer: expectations follow from the address rule and the NACK list.
  task automatic xfer_write(input logic [6:0] addr, input bit do_stop, input int glitch_byte);
    bit m, ack;
    int rx0, low0, n;
    m    = (addr == own_addr);
    rx0  = rx_cnt;
    low0 = dut_low;
    n    = wr_bytes.size();
    bus_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    write_byte({addr, 1'b0}, -1, ack);
    chk("wr_addr_ack", 32'(ack), 32'(m));
    chk("wr_addressed", 32'(addressed), 32'(m));
    for (int i = 0; i < n; i++) begin
      fab.rx_nack = wr_nack[i];
      if (m) exp_rx.push_back(wr_bytes[i]);
      write_byte(wr_bytes[i], (i == glitch_byte) ? 4 : -1, ack);
      chk("wr_data_ack", 32'(ack), 32'(m && !wr_nack[i]));
    end
    fab.rx_nack = 1'b0;
    chk("rx_pulses", 32'(rx_cnt - rx0), m ? 32'(n) : 32'd0);
    if (!m) begin
      chk("unaddr_sda_low", 32'(dut_low - low0), 32'd0);
      chk("unaddr_busy", 32'(busy), 32'd1);
    end
    if (do_stop) stop_checks();
    wr_bytes.delete();
    wr_nack.delete();
  endtask

  // Read transfer: master ACKs every byte except the last.
  task automatic xfer_read(input logic [6:0] addr, input bit do_stop);
    bit m, ack;
    int tx0, n;
    logic [7:0] got;
    m   = (addr == own_addr);
    tx0 = txn_cnt;
    n   = rd_bytes.size();
    if (m) foreach (rd_bytes[i]) tx_src.push_back(rd_bytes[i]);
    bus_start();
    write_byte({addr, 1'b1}, -1, ack);
    chk("rd_addr_ack", 32'(ack), 32'(m));
    if (m) chk("read_mode", 32'(read_mode), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(got, i < n - 1);
      chk("rd_byte", 32'(got), m ? 32'(rd_bytes[i]) : 32'hFF);
    end
    chk("sda_released_after_nack", 32'(sda), 32'd1);
    chk("tx_pulses", 32'(txn_cnt - tx0), m ? 32'(n) : 32'd0);
    chk("tx_src_drained", 32'(tx_src.size()), 32'd0);
    if (do_stop) stop_checks();
    rd_bytes.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ack;
    int low0, rx0;
    logic [7:0] d;
    fab.tx_data = 8'h00;
    fab.rx_nack = 1'b0;
    m_scl = 1'b1;
    m_sda_low = 1'b0;
    own_addr = 7'h42;
    rst_n = 1'b0;
    wait_clk(4);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addressed", 32'(addressed), 32'd0);
    chk("rst_read_mode", 32'(read_mode), 32'd0);
    chk("rst_stop_det", 32'(stop_det), 32'd0);
    chk("rst_rx_data", 32'(fab.rx_data), 32'h00);
    chk("rst_rx_valid", 32'(fab.rx_data_valid), 32'd0);
    chk("rst_tx_needed", 32'(fab.tx_data_needed), 32'd0);
    chk("rst_sda", 32'(sda), 32'd1);
    rst_n = 1'b1;
    wait_clk(2 * Q);

    // Plain write
    wr_bytes = '{8'hA5, 8'h3C}; wr_nack = '{1'b0, 1'b0};
    xfer_write(7'h42, 1'b1, -1);

    // Plain read, ACK then NACK
    rd_bytes = '{8'h5A, 8'hC3};
    xfer_read(7'h42, 1'b1);

    // Address mismatch (0xA0)
    wr_bytes = '{8'h12, 8'h34}; wr_nack = '{1'b0, 1'b0};
    xfer_write(7'h50, 1'b1, -1);

    // Repeated START: write then read
    wr_bytes = '{8'h11}; wr_nack = '{1'b0};
    xfer_write(7'h42, 1'b0, -1);
    chk("rd_mode_before_sr", 32'(read_mode), 32'd0);
    chk("rx_data_hold", 32'(fab.rx_data), 32'h11);
    rd_bytes = '{8'h96};
    xfer_read(7'h42, 1'b1);

    // SCL glitch mid-byte, then a NACKed byte followed by a normal one
    wr_bytes = '{8'h5B}; wr_nack = '{1'b0};
    xfer_write(7'h42, 1'b1, 0);
    wr_bytes = '{8'h77, 8'h12}; wr_nack = '{1'b1, 1'b0};
    xfer_write(7'h42, 1'b1, -1);

    // General call only answered when own address is zero
    wr_bytes = '{8'hE1}; wr_nack = '{1'b0};
    xfer_write(7'h00, 1'b1, -1);
    own_addr = 7'h00;
    wr_bytes = '{8'hE2}; wr_nack = '{1'b0};
    xfer_write(7'h00, 1'b1, -1);
    own_addr = 7'h42;

    // Reset while the target pulls SDA low during a read
    tx_src.push_back(8'h00);
    bus_start();
    write_byte(8'h85, -1, ack);
    chk("mid_rd_addr_ack", 32'(ack), 32'd1);
    chk("mid_rd_sda_low", 32'(sda), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_releases_sda", 32'(sda), 32'd1);
    wait_clk(3);
    rst_n = 1'b1;
    low0 = dut_low;
    rx0  = rx_cnt;
    d = 8'h84;
    for (int i = 7; i >= 0; i--) write_bit(d[i], 1'b0);
    read_bit(ack);
    chk("post_rst_no_ack", 32'(ack), 32'd1);
    chk("post_rst_sda_low", 32'(dut_low - low0), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_rx", 32'(rx_cnt - rx0), 32'd0);
    m_sda_low = 1'b0; wait_clk(Q);
    m_scl = 1'b1;     wait_clk(2 * Q);
    wr_bytes = '{8'hC7}; wr_nack = '{1'b0};
    xfer_write(7'h42, 1'b1, -1);

    // Randomized transfers
    for (int t = 0; t < 10; t++) begin
      logic [6:0] a;
      int n;
      own_addr = 7'($urandom_range(1, 127));
      a = ($urandom_range(0, 3) != 0) ? own_addr : 7'($urandom);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < n; i++) begin
          wr_bytes.push_back(8'($urandom));
          wr_nack.push_back($urandom_range(0, 3) == 0);
        end
        xfer_write(a, 1'b1, -1);
      end else begin
        for (int i = 0; i < n; i++) rd_bytes.push_back(8'($urandom));
        xfer_read(a, 1'b1);
      end
    end

    wait_clk(Q);
    chk("rx_scoreboard_empty", 32'(exp_rx.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
